// File: rtl/triangle_edge_sequencer_if.sv
// Vertex-in / edge-out handshake bundle for the triangle edge sequencer,
// plus the shared vector types (integer-unit signed fixed-point coordinates).
package vector;
    localparam int COORD_W = 16;
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } vector_t;
endpackage

interface triangle_edge_sequencer_if #(
    parameter int TAG_W = 4
);
    import vector::*;

    logic             in_valid;
    logic             in_ready;
    vector_t          in_v0;
    vector_t          in_v1;
    vector_t          in_v2;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    vector_t          out_e0;
    vector_t          out_e1;
    vector_t          out_e2;
    logic [2:0]       out_ovf;
    logic             out_overflow;
    logic             out_degenerate;
    logic [TAG_W-1:0] out_tag;

    // Upstream vertex fetch / downstream setup side.
    modport master (
        output in_valid, in_v0, in_v1, in_v2, in_tag, out_ready,
        input  in_ready, out_valid, out_e0, out_e1, out_e2,
               out_ovf, out_overflow, out_degenerate, out_tag
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_v0, in_v1, in_v2, in_tag, out_ready,
        output in_ready, out_valid, out_e0, out_e1, out_e2,
               out_ovf, out_overflow, out_degenerate, out_tag
    );
endinterface

// File: rtl/triangle_edge_sequencer.sv
// Computes triangle edge vectors e0=v1-v0, e1=v2-v1, e2=v0-v2 by sharing one
// vector subtractor over three consecutive cycles.
module vector_sub (
    input  vector::vector_t i_op1,
    input  vector::vector_t i_op2,
    output vector::vector_t o_res,
    output logic [2:0]      o_ovf
);
    localparam int MSB = vector::COORD_W - 1;

    // NOTE: combinational logic uses blocking '='; every output is assigned on every pass, so no latch.
    always_comb begin
        o_res.x  = i_op1.x - i_op2.x;
        o_res.y  = i_op1.y - i_op2.y;
        o_res.z  = i_op1.z - i_op2.z;
        // Signed overflow: operands differ in sign and the result's sign differs from op1.
        o_ovf[0] = (i_op1.x[MSB] != i_op2.x[MSB]) && (o_res.x[MSB] != i_op1.x[MSB]);
        o_ovf[1] = (i_op1.y[MSB] != i_op2.y[MSB]) && (o_res.y[MSB] != i_op1.y[MSB]);
        o_ovf[2] = (i_op1.z[MSB] != i_op2.z[MSB]) && (o_res.z[MSB] != i_op1.z[MSB]);
    end
endmodule

module triangle_edge_sequencer #(
    parameter int TAG_W       = 4,
    parameter bit DEGEN_CHECK = 1'b1
) (
    input logic                      clk,
    input logic                      rst,
    triangle_edge_sequencer_if.slave bus
);
    import vector::*;

    typedef enum logic [2:0] {S_IDLE, S_SUB0, S_SUB1, S_SUB2, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next_state;
    vector_t          r_v0, r_v1, r_v2;
    vector_t          r_e0, r_e1, r_e2;
    logic [2:0]       r_ovf;
    logic [TAG_W-1:0] r_tag;

    vector_t          w_op1, w_op2, w_res;
    logic [2:0]       w_axis_ovf;
    logic             w_accept;
    logic             w_degen;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    vector_sub u_sub (
        .i_op1 (w_op1),
        .i_op2 (w_op2),
        .o_res (w_res),
        .o_ovf (w_axis_ovf)
    );

    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_op1        = '0;
        w_op2        = '0;
        unique case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_SUB0;
            S_SUB0: begin w_op1 = r_v1; w_op2 = r_v0; w_next_state = S_SUB1; end
            S_SUB1: begin w_op1 = r_v2; w_op2 = r_v1; w_next_state = S_SUB2; end
            S_SUB2: begin w_op1 = r_v0; w_op2 = r_v2; w_next_state = S_DONE; end
            S_DONE: if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, because every out_* field must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0  <= '0;
            r_v1  <= '0;
            r_v2  <= '0;
            r_tag <= '0;
            r_e0  <= '0;
            r_e1  <= '0;
            r_e2  <= '0;
            r_ovf <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_v0  <= bus.in_v0;
                    r_v1  <= bus.in_v1;
                    r_v2  <= bus.in_v2;
                    r_tag <= bus.in_tag;
                    r_e0  <= '0;
                    r_e1  <= '0;
                    r_e2  <= '0;
                    r_ovf <= '0;
                end
                S_SUB0: begin r_e0 <= w_res; r_ovf[0] <= |w_axis_ovf; end
                S_SUB1: begin r_e1 <= w_res; r_ovf[1] <= |w_axis_ovf; end
                S_SUB2: begin r_e2 <= w_res; r_ovf[2] <= |w_axis_ovf; end
                default: ;
            endcase
        end
    end

    generate
        if (DEGEN_CHECK) begin : g_degen
            assign w_degen = (r_e0 == '0) || (r_e1 == '0) || (r_e2 == '0);
        end else begin : g_no_degen
            assign w_degen = 1'b0;
        end
    endgenerate

    assign bus.in_ready       = (r_state == S_IDLE);
    assign bus.out_valid      = (r_state == S_DONE);
    assign bus.out_e0         = r_e0;
    assign bus.out_e1         = r_e1;
    assign bus.out_e2         = r_e2;
    assign bus.out_ovf        = r_ovf;
    assign bus.out_overflow   = |r_ovf;
    // Edge registers read zero outside a result, so the flag is qualified by DONE.
    assign bus.out_degenerate = (r_state == S_DONE) && w_degen;
    assign bus.out_tag        = r_tag;
endmodule

// File: tb/tb_triangle_edge_sequencer.sv
// Self-checking bench for triangle_edge_sequencer: directed scenarios plus a
// randomized stream scored against an integer-arithmetic reference model.
module tb_triangle_edge_sequencer;
    import vector::*;

    localparam int TAG_W = 4;

    typedef struct packed {
        vector_t          e0;
        vector_t          e1;
        vector_t          e2;
        logic [2:0]       ovf;
        logic             overflow;
        logic             degen;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    triangle_edge_sequencer_if #(.TAG_W(TAG_W)) bus ();
    triangle_edge_sequencer_if #(.TAG_W(TAG_W)) bus_nd ();

    // Second instance without the degenerate check, fed the same stimulus.
    assign bus_nd.in_valid  = bus.in_valid;
    assign bus_nd.in_v0     = bus.in_v0;
    assign bus_nd.in_v1     = bus.in_v1;
    assign bus_nd.in_v2     = bus.in_v2;
    assign bus_nd.in_tag    = bus.in_tag;
    assign bus_nd.out_ready = bus.out_ready;

    triangle_edge_sequencer #(.TAG_W(TAG_W), .DEGEN_CHECK(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    triangle_edge_sequencer #(.TAG_W(TAG_W), .DEGEN_CHECK(1'b0)) u_dut_nd (
        .clk (clk),
        .rst (rst),
        .bus (bus_nd.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic vector_t vec(input int x, input int y, input int z);
        vector_t v;
        v.x = 16'(x);
        v.y = 16'(y);
        v.z = 16'(z);
        return v;
    endfunction

    function automatic void sub_axis(input coord_t a, input coord_t b, output coord_t r, output bit o);
        int d;
        d = int'(a) - int'(b);
        r = 16'(d);
        o = (d > 32767) || (d < -32768);
    endfunction

    function automatic res_t model(input vector_t v0, input vector_t v1, input vector_t v2,
                                   input logic [TAG_W-1:0] tag, input bit degen_en);
        vector_t    lhs [3];
        vector_t    rhs [3];
        vector_t    e   [3];
        logic [2:0] ovf;
        res_t       r;
        lhs[0] = v1; rhs[0] = v0;
        lhs[1] = v2; rhs[1] = v1;
        lhs[2] = v0; rhs[2] = v2;
        for (int i = 0; i < 3; i++) begin
            bit ox, oy, oz;
            sub_axis(lhs[i].x, rhs[i].x, e[i].x, ox);
            sub_axis(lhs[i].y, rhs[i].y, e[i].y, oy);
            sub_axis(lhs[i].z, rhs[i].z, e[i].z, oz);
            ovf[i] = ox | oy | oz;
        end
        r.e0       = e[0];
        r.e1       = e[1];
        r.e2       = e[2];
        r.ovf      = ovf;
        r.overflow = |ovf;
        r.degen    = degen_en && ((e[0] == '0) || (e[1] == '0) || (e[2] == '0));
        r.tag      = tag;
        return r;
    endfunction

    function automatic res_t observe(input bit nd);
        res_t r;
        if (nd) begin
            r.e0 = bus_nd.out_e0; r.e1 = bus_nd.out_e1; r.e2 = bus_nd.out_e2;
            r.ovf = bus_nd.out_ovf; r.overflow = bus_nd.out_overflow;
            r.degen = bus_nd.out_degenerate; r.tag = bus_nd.out_tag;
        end else begin
            r.e0 = bus.out_e0; r.e1 = bus.out_e1; r.e2 = bus.out_e2;
            r.ovf = bus.out_ovf; r.overflow = bus.out_overflow;
            r.degen = bus.out_degenerate; r.tag = bus.out_tag;
        end
        return r;
    endfunction

    function automatic vector_t rand_vec();
        return vec(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 65535)));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vector_t v0, input vector_t v1, input vector_t v2,
                        input logic [TAG_W-1:0] tag);
        bit ok;
        ok = 1'b0;
        bus.in_v0 = v0; bus.in_v1 = v1; bus.in_v2 = v2; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL send_accept: accepted=%0b required=1 within 50 cycles", ok);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || observe(0) !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b outs=%h required 1/0/0",
                     bus.in_ready, bus.out_valid, observe(0));
        end
    endtask

    task automatic test_basic();
        res_t exp;
        int   lat;
        bus.out_ready = 1'b1;
        exp = model(vec(0, 0, 0), vec(2, 0, 0), vec(0, 3, 0), 4'd5, 1'b1);
        send(vec(0, 0, 0), vec(2, 0, 0), vec(0, 3, 0), 4'd5);
        wait_out(lat);
        // Accept edge, then SUB0/SUB1/SUB2 edges: valid in the fourth cycle after acceptance.
        n_cmp++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL basic_latency: edges to out_valid=%0d required 3", lat);
        end
        n_cmp++;
        if (observe(0) !== exp || bus.out_e1 !== vec(-2, 3, 0) || bus.out_tag !== 4'd5) begin
            n_fail++;
            $display("FAIL basic_result: got %h required %h", observe(0), exp);
        end
        tick();
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_return_idle: in_ready=%0b out_valid=%0b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        res_t exp_a, exp_b;
        int   lat;
        int   bad;
        bus.out_ready = 1'b0;
        exp_a = model(vec(0, 0, 0), vec(2, 0, 0), vec(0, 3, 0), 4'd5, 1'b1);
        exp_b = model(vec(7, -3, 9), vec(-100, 20, 1), vec(300, 300, -2), 4'd9, 1'b1);
        send(vec(0, 0, 0), vec(2, 0, 0), vec(0, 3, 0), 4'd5);
        wait_out(lat);
        bus.in_v0 = vec(7, -3, 9); bus.in_v1 = vec(-100, 20, 1); bus.in_v2 = vec(300, 300, -2);
        bus.in_tag = 4'd9;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (observe(0) !== exp_a || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: unstable cycles=%0d required 0", bad);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        wait_out(lat);
        n_cmp++;
        if (observe(0) !== exp_b || lat !== 3) begin
            n_fail++;
            $display("FAIL backpressure_second: got %h lat=%0d required %h lat=3",
                     observe(0), lat, exp_b);
        end
        tick();
    endtask

    task automatic test_overflow();
        res_t exp;
        int   lat;
        bus.out_ready = 1'b1;
        exp = model(vec(-1, 0, 0), vec(32767, 0, 0), vec(-1, 0, 0), 4'd3, 1'b1);
        send(vec(-1, 0, 0), vec(32767, 0, 0), vec(-1, 0, 0), 4'd3);
        wait_out(lat);
        n_cmp++;
        if (observe(0) !== exp) begin
            n_fail++;
            $display("FAIL overflow_result: got %h required %h", observe(0), exp);
        end
        n_cmp++;
        if (bus.out_ovf !== 3'b001 || bus.out_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flags: ovf=%b overflow=%0b required 001/1",
                     bus.out_ovf, bus.out_overflow);
        end
        tick();
    endtask

    task automatic test_degenerate();
        res_t exp, exp_nd;
        int   lat;
        bus.out_ready = 1'b1;
        exp    = model(vec(1, 1, 1), vec(1, 1, 1), vec(4, 0, 0), 4'd12, 1'b1);
        exp_nd = model(vec(1, 1, 1), vec(1, 1, 1), vec(4, 0, 0), 4'd12, 1'b0);
        send(vec(1, 1, 1), vec(1, 1, 1), vec(4, 0, 0), 4'd12);
        wait_out(lat);
        n_cmp++;
        if (observe(0) !== exp || bus.out_degenerate !== 1'b1) begin
            n_fail++;
            $display("FAIL degenerate_on: got %h required %h", observe(0), exp);
        end
        n_cmp++;
        if (bus_nd.out_valid !== 1'b1 || observe(1) !== exp_nd || bus_nd.out_degenerate !== 1'b0) begin
            n_fail++;
            $display("FAIL degenerate_off: got %h required %h", observe(1), exp_nd);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        res_t exp;
        int   lat;
        bus.out_ready = 1'b1;
        send(vec(-1, 0, 0), vec(32767, 0, 0), vec(5, 5, 5), 4'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || observe(0) !== '0) begin
            n_fail++;
            $display("FAIL reset_midop_state: in_ready=%0b out_valid=%0b outs=%h required 1/0/0",
                     bus.in_ready, bus.out_valid, observe(0));
        end
        exp = model(vec(10, 20, 30), vec(-5, 8, 100), vec(0, 0, -7), 4'd2, 1'b1);
        send(vec(10, 20, 30), vec(-5, 8, 100), vec(0, 0, -7), 4'd2);
        wait_out(lat);
        n_cmp++;
        if (observe(0) !== exp || bus.out_ovf !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_midop_next: got %h required %h", observe(0), exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t exp;
        int   sent, recv, cyc;
        bit   fire_in;
        sent = 0;
        recv = 0;
        cyc  = 0;
        bus.in_valid = 1'b0;
        while ((sent < 20 || recv < 20) && cyc < 3000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (!bus.in_valid && sent < 20 && $urandom_range(0, 3) != 0) begin
                bus.in_v0 = rand_vec();
                bus.in_v1 = ($urandom_range(0, 3) == 0) ? bus.in_v0 : rand_vec();
                bus.in_v2 = rand_vec();
                bus.in_tag = 4'($urandom_range(0, 15));
                bus.in_valid = 1'b1;
            end
            fire_in = bus.in_valid && bus.in_ready;
            if (fire_in) begin
                exp_q.push_back(model(bus.in_v0, bus.in_v1, bus.in_v2, bus.in_tag, 1'b1));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                recv++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %h required no output", observe(0));
                end else begin
                    exp = exp_q.pop_front();
                    if (observe(0) !== exp) begin
                        n_fail++;
                        $display("FAIL stream_result[%0d]: got %h required %h", recv, observe(0), exp);
                    end
                end
            end
            tick();
            if (fire_in) bus.in_valid = 1'b0;
            cyc++;
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (recv != 20 || exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_count: received=%0d pending=%0d out_valid=%0b required 20/0/0",
                     recv, exp_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_v0     = '0;
        bus.in_v1     = '0;
        bus.in_v2     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_degenerate();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
